// File: rtl/wbu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : wbu_ctrl
//  Brief    : Write-back controller; retires one instruction at a time,
//             waiting for load data when needed, and writes the register file.
//  Revision : 1.0
// ============================================================================
module wbu_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_wen,
    input  logic        ex_mem_to_reg,
    input  logic        ex_jump,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_snpc,
    input  logic [31:0] ex_dnpc,
    input  logic        lsu_rvalid,
    input  logic [31:0] lsu_rdata,
    output logic        lsu_rready,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        commit_valid,
    input  logic        commit_ready,
    output logic [31:0] commit_pc,
    output logic [31:0] instret
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_LOAD = 2'd1,
        S_COMMIT    = 2'd2
    } state_t;

    state_t      state_q;
    logic        ex_ready_q;
    logic        lsu_rready_q;
    logic        commit_valid_q;
    logic [4:0]  rd_q;
    logic        reg_wen_q;
    logic        mem_to_reg_q;
    logic        jump_q;
    logic [31:0] alu_q;
    logic [31:0] snpc_q;
    logic [31:0] dnpc_q;
    logic [31:0] ld_data_q;
    logic [31:0] instret_q;
    logic [31:0] instret_d;

    assign instret_d = instret_q + 32'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            ex_ready_q     <= 1'b1;
            lsu_rready_q   <= 1'b0;
            commit_valid_q <= 1'b0;
            rd_q           <= 5'd0;
            reg_wen_q      <= 1'b0;
            mem_to_reg_q   <= 1'b0;
            jump_q         <= 1'b0;
            alu_q          <= 32'd0;
            snpc_q         <= 32'd0;
            dnpc_q         <= 32'd0;
            ld_data_q      <= 32'd0;
            instret_q      <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ex_valid && ex_ready_q) begin
                        rd_q         <= ex_rd;
                        reg_wen_q    <= ex_reg_wen;
                        mem_to_reg_q <= ex_mem_to_reg;
                        jump_q       <= ex_jump;
                        alu_q        <= ex_alu_result;
                        snpc_q       <= ex_snpc;
                        dnpc_q       <= ex_dnpc;
                        ex_ready_q   <= 1'b0;
                        // A jump that is also flagged as a load still links snpc
                        if (ex_mem_to_reg && !ex_jump) begin
                            state_q      <= S_WAIT_LOAD;
                            lsu_rready_q <= 1'b1;
                        end else begin
                            state_q        <= S_COMMIT;
                            commit_valid_q <= 1'b1;
                        end
                    end
                end
                S_WAIT_LOAD: begin
                    if (lsu_rvalid) begin
                        ld_data_q      <= lsu_rdata;
                        state_q        <= S_COMMIT;
                        lsu_rready_q   <= 1'b0;
                        commit_valid_q <= 1'b1;
                    end
                end
                S_COMMIT: begin
                    if (commit_ready) begin
                        instret_q      <= instret_d;
                        state_q        <= S_IDLE;
                        commit_valid_q <= 1'b0;
                        ex_ready_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q        <= S_IDLE;
                    ex_ready_q     <= 1'b1;
                    lsu_rready_q   <= 1'b0;
                    commit_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign ex_ready     = ex_ready_q;
    assign lsu_rready   = lsu_rready_q;
    assign commit_valid = commit_valid_q;
    assign commit_pc    = dnpc_q;
    assign instret      = instret_q;
    assign rf_waddr     = rd_q;
    assign rf_wdata     = jump_q       ? snpc_q    :
                          mem_to_reg_q ? ld_data_q : alu_q;
    // The write must land in the handshake cycle itself, so it follows commit_ready directly
    assign rf_wen       = commit_valid_q && commit_ready && reg_wen_q && (rd_q != 5'd0);

endmodule
`default_nettype wire

// File: tb/tb_wbu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wbu_ctrl
//  Brief    : Directed self-checking bench for wbu_ctrl.
//  Revision : 1.0
// ============================================================================
module tb_wbu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic        ex_reg_wen;
    logic        ex_mem_to_reg;
    logic        ex_jump;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_snpc;
    logic [31:0] ex_dnpc;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic        lsu_rready;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        commit_valid;
    logic        commit_ready;
    logic [31:0] commit_pc;
    logic [31:0] instret;

    int n_checks = 0;
    int n_pass   = 0;

    wbu_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_rd        (ex_rd),
        .ex_reg_wen   (ex_reg_wen),
        .ex_mem_to_reg(ex_mem_to_reg),
        .ex_jump      (ex_jump),
        .ex_alu_result(ex_alu_result),
        .ex_snpc      (ex_snpc),
        .ex_dnpc      (ex_dnpc),
        .lsu_rvalid   (lsu_rvalid),
        .lsu_rdata    (lsu_rdata),
        .lsu_rready   (lsu_rready),
        .rf_wen       (rf_wen),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .commit_pc    (commit_pc),
        .instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction for a single accepting cycle
    task automatic issue(input logic [4:0] rd, input logic wen, input logic m2r,
                         input logic jmp, input logic [31:0] alu,
                         input logic [31:0] snpc, input logic [31:0] dnpc);
        ex_valid      = 1'b1;
        ex_rd         = rd;
        ex_reg_wen    = wen;
        ex_mem_to_reg = m2r;
        ex_jump       = jmp;
        ex_alu_result = alu;
        ex_snpc       = snpc;
        ex_dnpc       = dnpc;
        #1;
        check("issue_ex_ready", {31'd0, ex_ready}, 32'd1);
        tick();
        ex_valid      = 1'b0;
        ex_alu_result = 32'hFFFF_FFFF;
        ex_snpc       = 32'hFFFF_FFFF;
        ex_dnpc       = 32'hFFFF_FFFF;
        ex_rd         = 5'd31;
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; ex_rd = 5'd0; ex_reg_wen = 1'b0;
        ex_mem_to_reg = 1'b0; ex_jump = 1'b0; ex_alu_result = 32'd0;
        ex_snpc = 32'd0; ex_dnpc = 32'd0; lsu_rvalid = 1'b0; lsu_rdata = 32'd0;
        commit_ready = 1'b1;
        #12;
        check("rst_commit_valid", {31'd0, commit_valid}, 32'd0);
        check("rst_lsu_rready",   {31'd0, lsu_rready},   32'd0);
        check("rst_rf_wen",       {31'd0, rf_wen},       32'd0);
        check("rst_instret",      instret,               32'd0);
        check("rst_commit_pc",    commit_pc,             32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_ex_ready", {31'd0, ex_ready}, 32'd1);

        // ALU op
        issue(5'd5, 1'b1, 1'b0, 1'b0, 32'h1234, 32'h8000_0004, 32'h8000_0004);
        check("alu_commit_valid", {31'd0, commit_valid}, 32'd1);
        check("alu_ex_ready",     {31'd0, ex_ready},     32'd0);
        check("alu_rf_wen",       {31'd0, rf_wen},       32'd1);
        check("alu_waddr",        {27'd0, rf_waddr},     32'd5);
        check("alu_wdata",        rf_wdata,              32'h1234);
        check("alu_pc",           commit_pc,             32'h8000_0004);
        tick();
        check("alu_rf_wen_after", {31'd0, rf_wen},       32'd0);
        check("alu_cv_after",     {31'd0, commit_valid}, 32'd0);
        check("alu_instret",      instret,               32'd1);

        // Load with 4-cycle late response
        issue(5'd3, 1'b1, 1'b1, 1'b0, 32'h0000_0AAA, 32'h8000_0008, 32'h8000_0008);
        for (int i = 0; i < 4; i++) begin
            check("ld_rready_wait", {31'd0, lsu_rready},   32'd1);
            check("ld_cv_wait",     {31'd0, commit_valid}, 32'd0);
            tick();
        end
        lsu_rvalid = 1'b1; lsu_rdata = 32'hDEAD_BEEF;
        #1;
        check("ld_rready_rvalid", {31'd0, lsu_rready}, 32'd1);
        tick();
        lsu_rvalid = 1'b0; lsu_rdata = 32'h0;
        #1;
        check("ld_commit_valid", {31'd0, commit_valid}, 32'd1);
        check("ld_rready_off",   {31'd0, lsu_rready},   32'd0);
        check("ld_wdata",        rf_wdata,              32'hDEAD_BEEF);
        check("ld_waddr",        {27'd0, rf_waddr},     32'd3);
        check("ld_rf_wen",       {31'd0, rf_wen},       32'd1);
        tick();
        check("ld_instret",      instret,               32'd2);

        // JAL, also flagged mem_to_reg: must behave as a jump
        issue(5'd1, 1'b1, 1'b1, 1'b1, 32'h0000_0777, 32'h8000_0008, 32'h8000_0100);
        check("jal_lsu_rready",   {31'd0, lsu_rready},   32'd0);
        check("jal_commit_valid", {31'd0, commit_valid}, 32'd1);
        check("jal_wdata",        rf_wdata,              32'h8000_0008);
        check("jal_pc",           commit_pc,             32'h8000_0100);
        check("jal_rf_wen",       {31'd0, rf_wen},       32'd1);
        tick();
        check("jal_instret",      instret,               32'd3);

        // rd = 0 never writes
        issue(5'd0, 1'b1, 1'b0, 1'b0, 32'h5555, 32'h4, 32'h8);
        check("x0_commit_valid", {31'd0, commit_valid}, 32'd1);
        check("x0_rf_wen",       {31'd0, rf_wen},       32'd0);
        tick();
        check("x0_instret",      instret,               32'd4);

        // reg_wen = 0 never writes
        issue(5'd9, 1'b0, 1'b0, 1'b0, 32'h6666, 32'h4, 32'h8);
        check("nowen_rf_wen",   {31'd0, rf_wen}, 32'd0);
        tick();
        check("nowen_instret",  instret,         32'd5);

        // Back-pressure on commit; a stray rvalid in COMMIT is ignored
        commit_ready = 1'b0;
        issue(5'd7, 1'b1, 1'b1, 1'b0, 32'h0, 32'h104, 32'h200);
        lsu_rvalid = 1'b1; lsu_rdata = 32'h0000_0055;
        tick();
        lsu_rdata = 32'h0000_0BAD;
        for (int i = 0; i < 3; i++) begin
            check("stall_cv",      {31'd0, commit_valid}, 32'd1);
            check("stall_rf_wen",  {31'd0, rf_wen},       32'd0);
            check("stall_wdata",   rf_wdata,              32'h55);
            check("stall_pc",      commit_pc,             32'h200);
            check("stall_ex_rdy",  {31'd0, ex_ready},     32'd0);
            tick();
        end
        lsu_rvalid = 1'b0;
        commit_ready = 1'b1;
        #1;
        check("stall_release_wen", {31'd0, rf_wen},   32'd1);
        check("stall_release_wd",  rf_wdata,          32'h55);
        tick();
        check("stall_wen_once",    {31'd0, rf_wen},   32'd0);
        check("stall_instret",     instret,           32'd6);

        // Reset asserted while waiting for load data
        issue(5'd4, 1'b1, 1'b1, 1'b0, 32'h0, 32'h4, 32'h8);
        tick();
        check("mid_rst_pre_rready", {31'd0, lsu_rready}, 32'd1);
        lsu_rvalid = 1'b1; lsu_rdata = 32'h1111_2222;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rready",  {31'd0, lsu_rready},   32'd0);
        check("mid_rst_cv",      {31'd0, commit_valid}, 32'd0);
        check("mid_rst_rf_wen",  {31'd0, rf_wen},       32'd0);
        check("mid_rst_instret", instret,               32'd0);
        check("mid_rst_ex_rdy",  {31'd0, ex_ready},     32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst2_ex_rdy", {31'd0, ex_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("post_rst2_cv",  {31'd0, commit_valid}, 32'd0);
            check("post_rst2_wen", {31'd0, rf_wen},       32'd0);
            tick();
        end
        lsu_rvalid = 1'b0;
        check("post_rst2_instret", instret, 32'd0);

        // instret wrap from a preloaded value
        force dut.instret_q = 32'hFFFF_FFFE;
        #1;
        release dut.instret_q;
        #1;
        check("wrap_preload", instret, 32'hFFFF_FFFE);
        @(negedge clk);
        issue(5'd2, 1'b1, 1'b0, 1'b0, 32'h1, 32'h4, 32'h8);
        tick();
        check("wrap_ffff", instret, 32'hFFFF_FFFF);
        issue(5'd2, 1'b1, 1'b0, 1'b0, 32'h2, 32'h4, 32'h8);
        tick();
        check("wrap_zero", instret, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wbu_ctrl.md
WBU_CTRL -- requirements
Module: wbu_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-003 SHALL have port ex_valid, input, 1: execute stage presents an instruction.
REQ-004 SHALL have port ex_ready, output, 1: controller accepts an instruction this cycle.
REQ-005 SHALL have ports ex_rd (input, 5), ex_reg_wen (input, 1), ex_mem_to_reg (input, 1), ex_jump (input, 1): destination register, write enable, load select, link select.
REQ-006 SHALL have ports ex_alu_result, ex_snpc, ex_dnpc, input, 32 each: ALU result, static next PC, dynamic next PC.
REQ-007 SHALL have ports lsu_rvalid (input, 1), lsu_rdata (input, 32), lsu_rready (output, 1): load-response handshake.
REQ-008 SHALL have ports rf_wen (output, 1), rf_waddr (output, 5), rf_wdata (output, 32): register-file write port.
REQ-009 SHALL have ports commit_valid (output, 1), commit_ready (input, 1), commit_pc (output, 32): retire handshake to fetch.
REQ-010 SHALL have port instret, output, 32: retired-instruction count.

Function
REQ-011 SHALL implement states IDLE, WAIT_LOAD, COMMIT.
REQ-012 SHALL drive ex_ready=1 only in IDLE.
REQ-013 SHALL, on ex_valid&&ex_ready, capture all ex_* fields into internal registers.
REQ-014 SHALL transition IDLE->WAIT_LOAD on acceptance with ex_mem_to_reg=1 and ex_jump=0; otherwise IDLE->COMMIT.
REQ-015 SHALL drive lsu_rready=1 only in WAIT_LOAD.
REQ-016 SHALL, in WAIT_LOAD on lsu_rvalid=1, capture lsu_rdata and go to COMMIT; it SHALL ignore lsu_rvalid in all other states.
REQ-017 SHALL select the write data as follows: captured snpc if jump=1, otherwise load data if mem_to_reg=1, otherwise alu_result. Jump takes priority over mem_to_reg.
REQ-018 SHALL drive commit_valid=1 in COMMIT only, with commit_pc equal to the captured dnpc, held stable until commit_ready.
REQ-019 SHALL hold commit_valid and all outputs stable while commit_ready=0 (no timeout).
REQ-020 SHALL assert rf_wen for exactly the single cycle where commit_valid&&commit_ready, and only if captured reg_wen=1 and rd!=0.
REQ-021 SHALL drive rf_waddr and rf_wdata from the captured rd and the selected data whenever in COMMIT.
REQ-022 SHALL, on commit_valid&&commit_ready, increment instret by 1 (modulo 2^32, 0xFFFFFFFF wraps to 0) and go to IDLE.
REQ-023 SHALL give a minimum latency from acceptance to commit_valid of 1 cycle for non-load instructions, and 1 cycle after the lsu_rvalid cycle for loads.
REQ-024 SHALL never accept a new instruction before the current one commits, so at most one instruction is in flight.
REQ-025 SHALL treat ex_mem_to_reg=1 with ex_jump=1 as a jump: it does not enter WAIT_LOAD and writes snpc.

Reset
REQ-026 SHALL, while rst_n=0, immediately force state=IDLE, instret=0, rf_wen=0, commit_valid=0, lsu_rready=0, and all captured registers=0, independent of clk.
REQ-027 SHALL abandon any in-flight instruction without a register write when reset is asserted mid-operation (WAIT_LOAD or COMMIT); no commit follows the release.
REQ-028 SHALL present ex_ready=1 in the first cycle after rst_n deasserts.

Verification
REQ-029 SHALL cover an ALU op with rd=5, alu_result=0x1234, dnpc=0x80000004 and commit_ready=1 -> commit_valid one cycle after acceptance, then a one-cycle rf_wen with waddr=5 and wdata=0x1234, then instret=1.
REQ-030 SHALL cover a load with rd=3 where lsu_rvalid arrives 4 cycles late with rdata=0xDEADBEEF -> lsu_rready is high in each of those 4 cycles, then a commit that writes 0xDEADBEEF to x3.
REQ-031 SHALL cover a JAL with rd=1, snpc=0x80000008, dnpc=0x80000100 -> wdata=0x80000008 and commit_pc=0x80000100.
REQ-032 SHALL cover a write to rd=0 with reg_wen=1 -> commit occurs, rf_wen stays 0, and instret increments.
REQ-033 SHALL cover commit_ready held at 0 for 3 cycles -> outputs stay stable and rf_wen stays 0, then exactly one rf_wen pulse when commit_ready=1.
REQ-034 SHALL cover rst_n pulsed low during WAIT_LOAD -> state returns to IDLE, no rf_wen pulse, and instret=0; also cover instret preloaded near 0xFFFFFFFF -> it wraps to 0.
